// File: rtl/key_scan_decoder_pkg.sv
// Shared definitions for the key scan receiver and the tone logic.
//   NKEYS     : keys per scan frame
//   IDX_W     : scan index width
//   state_t   : note FSM state {IDLE, HELD}
//   lowest_set: index of the lowest set bit (0 when none are set)
package key_scan_decoder_pkg;

   localparam int unsigned NKEYS = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      IDLE,
      HELD
   } state_t;

   // Monophonic priority: the lowest key index wins.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [NKEYS-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/key_scan_decoder_if.sv
// Scan-side and note-side signals of the key scan decoder.
//   ce, scan_idx, key_in           : scan step strobe, index, sense line (1 = pressed)
//   note, note_valid               : resolved held key and its valid flag
//   press_stb, rel_stb             : one-cycle press / release pulses
// master: the scan source / tone consumer; slave: key_scan_decoder.
interface key_scan_decoder_if;
   import key_scan_decoder_pkg::*;

   logic             ce;
   logic [IDX_W-1:0] scan_idx;
   logic             key_in;
   logic [IDX_W-1:0] note;
   logic             note_valid;
   logic             press_stb;
   logic             rel_stb;

   modport master (
      output ce, scan_idx, key_in,
      input  note, note_valid, press_stb, rel_stb
   );

   modport slave (
      input  ce, scan_idx, key_in,
      output note, note_valid, press_stb, rel_stb
   );

endinterface

// File: rtl/key_scan_decoder_key_debounce.sv
// One key's debouncer: a saturating agreement counter and the stable state.
// Build option KEY_SCAN_DEBOUNCE_EN: when undefined, samples go straight to
// the stable bit and no counter is built.
//   clk, rst_n : clock, asynchronous active-low reset
//   sample_en  : this key is being sampled this cycle
//   sample     : sensed level (1 = pressed)
//   stable     : registered debounced state
//   stable_nxt : value stable takes at the next edge
module key_debounce #(
   parameter int unsigned DEB_CNT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_en,
   input  logic sample,
   output logic stable,
   output logic stable_nxt
);

   if (DEB_CNT < 1 || DEB_CNT > 15) begin : g_bad_deb_cnt
      $error("DEB_CNT must be in 1..15");
   end

   logic stable_q, stable_d;

`ifdef KEY_SCAN_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEB_CNT + 1);
   localparam logic [CW-1:0] LastCnt = CW'(DEB_CNT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // The flip happens on the DEB_CNT-th disagreeing sample, so the counter
   // tops out at DEB_CNT-1 and cannot wrap.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sample_en) begin
         if (sample == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q == LastCnt) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end
`else
   always_comb begin
      stable_d = stable_q;
      if (sample_en) stable_d = sample;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stable_q <= 1'b0;
      else        stable_q <= stable_d;
   end
`endif

   assign stable     = stable_q;
   assign stable_nxt = stable_d;

endmodule

// File: rtl/key_scan_decoder.sv
// Receiving end of the 8-step key scan: per-key debounce, then at each frame
// end (CE with scan index 7) resolves one held note, lowest index first, and
// pulses press/release strobes. Build option KEY_SCAN_DEBOUNCE_EN enables the
// per-key debounce counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key_scan_decoder_if.slave (scan inputs, note outputs)
module key_scan_decoder
   import key_scan_decoder_pkg::*;
#(
   parameter int unsigned DEB_CNT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   key_scan_decoder_if.slave     bus
);

   logic [NKEYS-1:0] stable;
   logic [NKEYS-1:0] stable_nxt;
   logic [NKEYS-1:0] key_vec;
   logic             frame_end;
   logic [IDX_W-1:0] low_idx;

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      key_debounce #(
         .DEB_CNT (DEB_CNT)
      ) u_key_debounce (
         .clk        (clk),
         .rst_n      (rst_n),
         .sample_en  (bus.ce && (bus.scan_idx == IDX_W'(i))),
         .sample     (bus.key_in),
         .stable     (stable[i]),
         .stable_nxt (stable_nxt[i])
      );
   end

   // At frame end the resolution must already see key 7's sample from this
   // same cycle, so fold in the next-state vector whenever a sample lands.
   assign key_vec   = bus.ce ? stable_nxt : stable;
   assign frame_end = bus.ce && (bus.scan_idx == IDX_W'(NKEYS - 1));
   assign low_idx   = lowest_set(key_vec);

   state_t           state_q;
   logic [IDX_W-1:0] note_q;
   logic             note_valid_q;
   logic             press_stb_q;
   logic             rel_stb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         note_q       <= '0;
         note_valid_q <= 1'b0;
         press_stb_q  <= 1'b0;
         rel_stb_q    <= 1'b0;
      end else begin
         press_stb_q <= 1'b0;
         rel_stb_q   <= 1'b0;
         if (frame_end) begin
            unique case (state_q)
               IDLE: begin
                  if (|key_vec) begin
                     state_q      <= HELD;
                     note_q       <= low_idx;
                     note_valid_q <= 1'b1;
                     press_stb_q  <= 1'b1;
                  end
               end
               HELD: begin
                  if (!(|key_vec)) begin
                     // note_q keeps the last released key.
                     state_q      <= IDLE;
                     note_valid_q <= 1'b0;
                     rel_stb_q    <= 1'b1;
                  end else if (low_idx != note_q) begin
                     note_q      <= low_idx;
                     press_stb_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.note       = note_q;
   assign bus.note_valid = note_valid_q;
   assign bus.press_stb  = press_stb_q;
   assign bus.rel_stb    = rel_stb_q;

endmodule

// File: doc/key_scan_decoder.md
# key_scan_decoder

Receiving end of the piano's 8-step key scan. The 3-bit scan counter steps a column index on each CE strobe; this block samples the returned key-sense line at each index and debounces every key independently. At each scan-frame boundary it resolves a single held note (monophonic, lowest index wins) and emits press/release strobes for the tone-generation logic.

## Interface
- DEB_CNT, 4: consecutive agreeing samples (one per frame per key) required to change a key's stable state; legal 1..15.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- CE  in  1  scan step strobe; the same strobe that advances the scan counter.
- SCAN_IDX  in  3  current scan index from the 8-step counter.
- KEY_IN  in  1  sense line for key SCAN_IDX; 1 = pressed.
- NOTE  out  3  index of the resolved held key.
- NOTE_VALID  out  1  1 while a note is held.
- PRESS_STB  out  1  one-cycle pulse: new note, or note changed.
- REL_STB  out  1  one-cycle pulse: last key released.

## Operation
- Reset (RST=0, asynchronous): debounce counters, stable vector, FSM and all outputs go to 0; they stay at 0 while RST=0.
- Sampling occurs only on CLK edges with CE=1; KEY_IN is associated with key SCAN_IDX. With CE=0, no state changes apart from strobe clearing.
- Per-key debounce:
  - If the sample equals the key's stable state, its counter clears.
  - Otherwise the counter increments.
  - On reaching DEB_CNT, the stable state flips and the counter clears.
  - The counter is ceil(log2(DEB_CNT+1)) bits wide and never wraps.
- Frame end: a CE=1 cycle with SCAN_IDX=7. Resolution uses the stable vector including key 7's update from that same cycle.
- Out-of-order or repeated indices are legal. Each sample affects only its own key, and only index 7 ends a frame.
- FSM states:
  - IDLE to HELD at frame end if any stable key is set. NOTE takes the lowest set index, NOTE_VALID=1, PRESS_STB pulses.
  - HELD to HELD at frame end if the lowest set index differs from NOTE. NOTE updates and PRESS_STB pulses; REL_STB does not pulse.
  - HELD to IDLE at frame end if no stable key is set. NOTE_VALID=0, REL_STB pulses, and NOTE keeps its last value.
  - In any other case there is no change and no strobe.
- PRESS_STB and REL_STB are never high in the same cycle.

## Timing
- All outputs are registered and update on the CLK edge following the frame-end CE cycle (1-cycle latency from that cycle).
- Strobes are exactly one CLK cycle wide, independent of CE duty cycle.
- Minimum press latency: DEB_CNT frames. The press is reported after the DEB_CNT-th frame end at which the key reads pressed, counted from the first pressed sample.
- Release latency follows the same rule.
- Reset asserted mid-note: outputs drop to 0 asynchronously and no REL_STB is produced. After release, the next press needs a full DEB_CNT frames.

## Configuration
- KEY_SCAN_DEBOUNCE_EN defined: per-key debounce as described above.
- KEY_SCAN_DEBOUNCE_EN not defined:
  - Each sample is written directly to the stable vector.
  - DEB_CNT is ignored and no counters are built.
  - Press and release appear at the next frame end.

## Structure
- Shared package holds:
  - NKEYS=8 and IDX_W=3.
  - The FSM state enum {IDLE, HELD}.
  - The lowest-set-index priority function, reused by the tone logic.
- Sub-module key_debounce: one key's counter and stable bit, with inputs sample_en and sample, and output stable. It is instantiated NKEYS times, with sample_en = CE & (SCAN_IDX==i).

## Test plan
- DEB_CNT=4, debounce enabled, CE every 4th clock, SCAN_IDX cycling 0..7, key 5 held from frame 1 -> PRESS_STB exactly once, one clock after frame 4 end; NOTE=5, NOTE_VALID=1.
- Key 2 pressed for 2 frames, then released -> no strobe; NOTE_VALID stays 0.
- Keys 3 and 6 stable pressed -> NOTE=3; release key 3 -> after 4 frames NOTE=6 with a single PRESS_STB and no REL_STB.
- All keys released from HELD -> REL_STB one clock after the 4th released frame end; NOTE_VALID=0; NOTE holds its last value.
- RST pulled low asynchronously while HELD with NOTE=6 -> all outputs 0 before the next CLK edge; no strobe; re-press needs 4 frames.
- CE held low for 100 clocks with KEY_IN toggling -> no output or state change. Repeat with the macro undefined: key 1 pressed is reported at the first frame end.
